bus_ctrl: RTL

- Single-master system-bus controller between the processor memory port and its two slaves: the RAM and the UART.
- Decodes each CPU access into the RAM or UART region, forwards strobes, address and data to the selected slave, and steers that slave's read data back to the CPU.
- Stalls CPU writes to the UART while the UART is busy, with a timeout guard.
- Flags accesses to unmapped IO addresses.

---
 rtl/bus_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bus_ctrl.sv
// ---------------------------------------------------------------------------
// bus_ctrl -- single-master system-bus controller
//
// Sits between the CPU memory port and two slaves (RAM and UART). Each CPU
// access is decoded into the RAM or UART region and forwarded with zero
// latency while idle. Read data is steered back from the slave that took the
// last read strobe. A UART write issued while the UART is busy is parked in
// hold registers and the CPU is stalled until the UART frees up, or until a
// timeout expires and the write is dropped.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cpu_addr_i/rstrb_i/
//   wmask_i/wdata_i          CPU request (nonzero wmask = write)
//   cpu_rdata_o              read data, valid the cycle after the strobe
//   cpu_wbusy_o/rbusy_o      CPU stalls
//   ram_*_o / ram_rdata_i    RAM slave port
//   uart_*_o / uart_rdata_i  UART slave port
//   uart_busy_i              UART transmitter busy
//   err_o                    sticky: unmapped access, read+write collision,
//                            or dropped UART write
// ---------------------------------------------------------------------------
module bus_ctrl #(
   parameter int IO_CTRL_BIT   = 22,
   parameter int UART_CTRL_BIT = 1,
   parameter int TIMEOUT       = 1024,
   parameter int TO_W          = 11
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] cpu_addr_i,
   input  logic        cpu_rstrb_i,
   input  logic [3:0]  cpu_wmask_i,
   input  logic [31:0] cpu_wdata_i,
   output logic [31:0] cpu_rdata_o,
   output logic        cpu_wbusy_o,
   output logic        cpu_rbusy_o,
   output logic [31:0] ram_addr_o,
   output logic        ram_rstrb_o,
   output logic [3:0]  ram_wmask_o,
   output logic [31:0] ram_wdata_o,
   input  logic [31:0] ram_rdata_i,
   output logic [31:0] uart_addr_o,
   output logic        uart_rstrb_o,
   output logic [3:0]  uart_wmask_o,
   output logic [31:0] uart_wdata_o,
   input  logic [31:0] uart_rdata_i,
   input  logic        uart_busy_i,
   output logic        err_o
);

   typedef enum logic {S_IDLE, S_WR_HOLD} state_t;
   typedef enum logic [1:0] {RD_NONE, RD_RAM, RD_UART} rdsel_t;

   state_t          r_state;
   rdsel_t          r_rd_sel;
   logic [TO_W-1:0] r_cnt;
   logic            r_err;
   logic [3:0]      r_hmask;
   logic [31:0]     r_hdata;
   logic [31:0]     r_haddr;

   logic w_idle;
   logic w_hold;
   logic w_ram_sel;
   logic w_uart_sel;
   logic w_unmapped;
   logic w_wr;
   logic w_rd;
   logic w_stall;
   logic w_limit;
   logic w_hold_busy;

   // Decode
   assign w_ram_sel  = ~cpu_addr_i[IO_CTRL_BIT];
   assign w_uart_sel = cpu_addr_i[IO_CTRL_BIT] & cpu_addr_i[UART_CTRL_BIT + 2];
   assign w_unmapped = ~w_ram_sel & ~w_uart_sel;
   assign w_wr       = |cpu_wmask_i;
   // A read that collides with a write is not forwarded.
   assign w_rd       = cpu_rstrb_i & ~w_wr;

   // Gating by rst_ni keeps every strobe and mask low for the whole time
   // reset is held, not just from the next edge.
   assign w_idle = rst_ni & (r_state == S_IDLE);
   assign w_hold = rst_ni & (r_state == S_WR_HOLD);

   assign w_stall     = w_idle & w_wr & w_uart_sel & uart_busy_i;
   assign w_limit     = (r_cnt == TO_W'(TIMEOUT - 1));
   // The hold cycle that releases (UART free or timeout) already lets the
   // CPU go, so the CPU retires its request on that edge.
   assign w_hold_busy = w_hold & uart_busy_i & ~w_limit;

   assign cpu_wbusy_o = w_stall | w_hold_busy;
   assign cpu_rbusy_o = w_hold_busy;

   // RAM side: address and data always follow the CPU; only strobes gate.
   assign ram_addr_o  = cpu_addr_i;
   assign ram_wdata_o = cpu_wdata_i;
   assign ram_rstrb_o = w_idle & w_rd & w_ram_sel;
   assign ram_wmask_o = (w_idle & w_ram_sel) ? cpu_wmask_i : 4'h0;

   // UART side: during hold the parked write replaces the CPU request.
   assign uart_addr_o  = w_hold ? r_haddr : cpu_addr_i;
   assign uart_wdata_o = w_hold ? r_hdata : cpu_wdata_i;
   assign uart_rstrb_o = w_idle & w_rd & w_uart_sel;

   always_comb begin
      uart_wmask_o = 4'h0;
      if (w_idle & w_uart_sel & ~uart_busy_i)
         uart_wmask_o = cpu_wmask_i;
      else if (w_hold & ~uart_busy_i)
         uart_wmask_o = r_hmask;
   end

   always_comb begin
      cpu_rdata_o = 32'h0;
      case (r_rd_sel)
         RD_RAM:  cpu_rdata_o = ram_rdata_i;
         RD_UART: cpu_rdata_o = uart_rdata_i;
         default: cpu_rdata_o = 32'h0;
      endcase
   end

   assign err_o = r_err;

   // Control FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_rd_sel <= RD_NONE;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cpu_rstrb_i) begin
                  if (w_wr | w_unmapped) r_rd_sel <= RD_NONE;
                  else if (w_ram_sel)    r_rd_sel <= RD_RAM;
                  else                   r_rd_sel <= RD_UART;
               end
               if ((cpu_rstrb_i | w_wr) & w_unmapped) r_err <= 1'b1;
               if (cpu_rstrb_i & w_wr)                r_err <= 1'b1;
               if (w_stall) begin
                  r_state <= S_WR_HOLD;
                  r_cnt   <= '0;
               end
            end
            S_WR_HOLD: begin
               r_cnt <= r_cnt + TO_W'(1);
               // A UART that frees up on the limit cycle still gets the write.
               if (!uart_busy_i) begin
                  r_state <= S_IDLE;
               end else if (w_limit) begin
                  r_state <= S_IDLE;
                  r_err   <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Hold registers for the parked UART write (data only, no reset needed)
   always_ff @(posedge clk_i) begin
      if (w_stall) begin
         r_hmask <= cpu_wmask_i;
         r_hdata <= cpu_wdata_i;
         r_haddr <= cpu_addr_i;
      end
   end

endmodule
